pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock, rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: stallreq_if  in  1  fetch waiting on instruction memory.
REQ-004 SHALL have: stallreq_id  in  1  decode hazard (load-use).
REQ-005 SHALL have: stallreq_ex  in  1  execute multi-cycle op busy.
REQ-006 SHALL have: stallreq_mem  in  1  data memory busy.
REQ-007 SHALL have: branch_flag_i  in  1  taken branch/jump resolved in EX.
REQ-008 SHALL have: branch_target_i  in  32  redirect address, valid with branch_flag_i.
REQ-009 SHALL have: stall_o  out  6  per-stage hold, bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-010 SHALL have: flush_o  out  1  kill IF/ID and ID/EX contents, load PC.
REQ-011 SHALL have: new_pc_o  out  32  PC value loaded when flush_o=1.
REQ-012 SHALL have: stall_cycles_o  out  32  count of cycles with stall_o[0]=1.
REQ-013 SHALL have: flush_count_o  out  16  count of flush_o pulses.

Function
REQ-014 SHALL decode stall_o combinationally, highest priority first: mem 011111, ex 001111, id 000111, if 000011, else 000000.
REQ-015 SHALL implement FSM states RUN and PEND.
REQ-016 In RUN, branch_flag_i=1 with stallreq_mem=0 and stallreq_ex=0 SHALL assert flush_o same cycle, new_pc_o=branch_target_i, state stays RUN.
REQ-017 In RUN, branch_flag_i=1 with stallreq_mem or stallreq_ex high SHALL capture branch_target_i into pend_pc and go to PEND next edge; flush_o=0 that cycle.
REQ-018 In PEND, branch_flag_i SHALL be ignored; the first cycle with stallreq_mem=0 and stallreq_ex=0 SHALL assert flush_o with new_pc_o=pend_pc and return to RUN next edge.
REQ-019 While flush_o=1, stallreq_if and stallreq_id SHALL be ignored: stall_o=000000 (the instructions they protect are killed).
REQ-020 new_pc_o SHALL be 0 whenever flush_o=0.
REQ-021 stall_cycles_o SHALL increment by 1 each edge where stall_o[0]=1 and wrap from FFFFFFFF to 0.
REQ-022 flush_count_o SHALL increment on each edge where flush_o=1 and saturate at FFFF.
REQ-023 flush_o SHALL be high at most one cycle per branch event; back-to-back branches in consecutive RUN cycles SHALL each flush.

Reset
REQ-024 rst=1 at a clock edge SHALL set state RUN, pend_pc 0, stall_cycles_o 0, flush_count_o 0.
REQ-025 While rst=1, stall_o SHALL be 000000, flush_o 0, new_pc_o 0, regardless of inputs.
REQ-026 rst in PEND SHALL discard the pending redirect; no flush follows reset release.

Structure
REQ-027 Stall codes (StallMem, StallEx, StallId, StallIf, NoStall), StallBus width, FSM state encodings SHALL live in the shared defines file.
REQ-028 Single module; no sub-modules; both counters inline.

Verification
REQ-029 stallreq_id=1 only -> stall_o=000111; add stallreq_mem=1 -> 011111; stall_cycles_o +1 per cycle.
REQ-030 RUN, branch_flag_i=1, target 0x00000100, no stalls -> flush_o=1, new_pc_o=0x00000100 same cycle, flush_count_o=1 next.
REQ-031 branch_flag_i=1, target 0x00000200, stallreq_mem=1 for 3 cycles -> flush_o=0 for 3 cycles, then one cycle flush_o=1, new_pc_o=0x00000200.
REQ-032 PEND with new branch_flag_i, target 0x300 -> ignored, flush uses original 0x200.
REQ-033 rst=1 while PEND -> after release no flush, counters 0, stall_o=000000.
REQ-034 Branch with stallreq_id=1, stallreq_if=1 -> flush_o=1, stall_o=000000; flush_count_o preloaded FFFF stays FFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stall codes, stall bus width and FSM state encodings
package pipe_ctrl_pkg;
    localparam int StallBus = 6;
    typedef logic [StallBus-1:0] stall_bus_t;
    localparam stall_bus_t StallMem = 6'b011111;
    localparam stall_bus_t StallEx  = 6'b001111;
    localparam stall_bus_t StallId  = 6'b000111;
    localparam stall_bus_t StallIf  = 6'b000011;
    localparam stall_bus_t NoStall  = 6'b000000;
    typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;
endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall decode, branch flush sequencing and event counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_if,
    input  logic                stallreq_id,
    input  logic                stallreq_ex,
    input  logic                stallreq_mem,
    input  logic                branch_flag_i,
    input  logic [31:0]         branch_target_i,
    output logic [StallBus-1:0] stall_o,
    output logic                flush_o,
    output logic [31:0]         new_pc_o,
    output logic [31:0]         stall_cycles_o,
    output logic [15:0]         flush_count_o
);
    state_t      r_state, w_next_state;
    logic [31:0] r_pend_pc, w_next_pend_pc;
    logic [31:0] r_stall_cycles;
    logic [15:0] r_flush_count;
    stall_bus_t  w_stall_req;
    logic        w_busy;

    // A redirect cannot be applied while EX or MEM still hold live instructions
    assign w_busy         = stallreq_mem | stallreq_ex;
    assign stall_cycles_o = r_stall_cycles;
    assign flush_o        = !rst && !w_busy && (r_state == PEND || branch_flag_i);

    // Priority decode of stall requests, the deepest stage wins
    always_comb begin
        w_stall_req = stallreq_mem ? StallMem :
                      stallreq_ex  ? StallEx  :
                      stallreq_id  ? StallId  :
                      stallreq_if  ? StallIf  : NoStall;
    end

    // Next state, pending target and redirect outputs; a flush kills the stalled front end
    always_comb begin
        w_next_state   = r_state;
        w_next_pend_pc = r_pend_pc;
        stall_o        = (rst || flush_o) ? NoStall : w_stall_req;
        new_pc_o       = '0;
        if (flush_o)
            new_pc_o = (r_state == PEND) ? r_pend_pc : branch_target_i;
        if (!rst && r_state == RUN && branch_flag_i && w_busy) begin
            w_next_state   = PEND;
            w_next_pend_pc = branch_target_i;
        end
        if (!rst && r_state == PEND && !w_busy)
            w_next_state = RUN;
    end

    // State and pending redirect register; reset drops any pending redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RUN;
            r_pend_pc <= '0;
        end else begin
            r_state   <= w_next_state;
            r_pend_pc <= w_next_pend_pc;
        end
    end

    // Stall cycle counter wraps, flush counter saturates
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (stall_o[0])
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (flush_o && r_flush_count != 16'hFFFF)
                r_flush_count <= r_flush_count + 16'd1;
        end
    end

    assign flush_count_o = r_flush_count;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: randomized and directed checks of pipe_ctrl against a behavioural model
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic [31:0] stall_cycles_o;
    logic [15:0] flush_count_o;
    int          checks = 0;
    int          errors = 0;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
        .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
        .stall_cycles_o(stall_cycles_o), .flush_count_o(flush_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic i, input logic d, input logic e,
                        input logic m, input logic b, input logic [31:0] t);
        @(posedge clk);
        #1;
        rst = r; stallreq_if = i; stallreq_id = d; stallreq_ex = e; stallreq_mem = m;
        branch_flag_i = b; branch_target_i = t;
        @(negedge clk);
    endtask

    // Behavioural reference: a pending-redirect flag, the held target and two counters
    initial begin
        logic        m_pending = 1'b0;
        logic [31:0] m_pend_pc = '0;
        logic [31:0] m_stall_cnt = '0;
        int          m_flush_cnt = 0;
        logic        e_flush = 1'b0;
        logic [5:0]  e_stall = '0;
        logic [31:0] e_pc;
        int          held;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_pending = 1'b0; m_pend_pc = '0; m_stall_cnt = '0; m_flush_cnt = 0;
            end else begin
                if (e_flush && m_flush_cnt < 65535) m_flush_cnt++;
                if (e_stall[0]) m_stall_cnt = m_stall_cnt + 1;
                if (!m_pending && branch_flag_i && (stallreq_mem || stallreq_ex)) begin
                    m_pending = 1'b1; m_pend_pc = branch_target_i;
                end else if (m_pending && !(stallreq_mem || stallreq_ex))
                    m_pending = 1'b0;
            end
            @(negedge clk);
            held = stallreq_mem ? 5 : stallreq_ex ? 4 : stallreq_id ? 3 : stallreq_if ? 2 : 0;
            e_flush = !rst && !(stallreq_mem || stallreq_ex) && (m_pending || branch_flag_i);
            e_pc = !e_flush ? 32'd0 : m_pending ? m_pend_pc : branch_target_i;
            e_stall = (rst || e_flush) ? 6'd0 : 6'((32'd1 << held) - 32'd1);
            check("m_stall", {26'd0, stall_o}, {26'd0, e_stall});
            check("m_flush", {31'd0, flush_o}, {31'd0, e_flush});
            check("m_new_pc", new_pc_o, e_pc);
            check("m_stall_cycles", stall_cycles_o, m_stall_cnt);
            check("m_flush_count", {16'd0, flush_count_o}, 32'(m_flush_cnt));
        end
    end

    initial begin
        step(1, 1, 1, 1, 1, 1, 32'h0000_0500);
        check("rst_stall", {26'd0, stall_o}, 32'd0);
        check("rst_flush", {31'd0, flush_o}, 32'd0);
        check("rst_new_pc", new_pc_o, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("rst_stall_cycles", stall_cycles_o, 32'd0);
        check("rst_flush_count", {16'd0, flush_count_o}, 32'd0);
        step(0, 0, 1, 0, 0, 0, 0);
        check("id_stall", {26'd0, stall_o}, 32'h07);
        step(0, 0, 1, 0, 1, 0, 0);
        check("mem_stall", {26'd0, stall_o}, 32'h1F);
        check("stall_cnt1", stall_cycles_o, 32'd1);
        step(0, 0, 0, 0, 0, 0, 0);
        check("stall_cnt2", stall_cycles_o, 32'd2);
        check("no_stall", {26'd0, stall_o}, 32'd0);
        step(0, 0, 0, 0, 0, 1, 32'h0000_0100);
        check("br_flush", {31'd0, flush_o}, 32'd1);
        check("br_pc", new_pc_o, 32'h100);
        step(0, 0, 0, 0, 0, 0, 0);
        check("br_count", {16'd0, flush_count_o}, 32'd1);
        check("br_once", {31'd0, flush_o}, 32'd0);
        step(0, 0, 0, 0, 1, 1, 32'h0000_0200);
        check("pend_c1", {31'd0, flush_o}, 32'd0);
        step(0, 0, 0, 0, 1, 1, 32'h0000_0300);
        check("pend_c2", {31'd0, flush_o}, 32'd0);
        step(0, 0, 0, 0, 1, 0, 0);
        check("pend_c3", {31'd0, flush_o}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("pend_flush", {31'd0, flush_o}, 32'd1);
        check("pend_pc", new_pc_o, 32'h200);
        step(0, 0, 0, 0, 0, 0, 0);
        check("pend_done", {31'd0, flush_o}, 32'd0);
        check("pend_count", {16'd0, flush_count_o}, 32'd2);
        step(0, 0, 0, 1, 0, 1, 32'h0000_0400);
        step(1, 0, 0, 0, 0, 0, 0);
        check("rst_pend_flush", {31'd0, flush_o}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("post_rst_flush", {31'd0, flush_o}, 32'd0);
        check("post_rst_stall", {26'd0, stall_o}, 32'd0);
        check("post_rst_fc", {16'd0, flush_count_o}, 32'd0);
        check("post_rst_sc", stall_cycles_o, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("post_rst_flush2", {31'd0, flush_o}, 32'd0);
        for (int n = 0; n < 3000; n++)
            step($urandom_range(63) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
                 $urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(2) == 0, $urandom);
        step(1, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 65540; n++)
            step(0, 0, 0, 0, 0, 1, n);
        step(0, 1, 1, 0, 0, 1, 32'h0000_0600);
        check("sat_count", {16'd0, flush_count_o}, 32'hFFFF);
        check("kill_flush", {31'd0, flush_o}, 32'd1);
        check("kill_stall", {26'd0, stall_o}, 32'd0);
        check("kill_pc", new_pc_o, 32'h600);
        step(0, 0, 0, 0, 0, 0, 0);
        check("sat_hold", {16'd0, flush_count_o}, 32'hFFFF);
        step(0, 0, 0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
